// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester (CPU MEM stage, debug/loader) arbiter and
// sequencer in front of a single data-memory port. Accepted requests are
// registered, drive the memory for one ACCESS cycle, and loads return
// registered data with a one-cycle valid pulse to the owning requester.
// Optional macro DMEM_ARB_ROUND_ROBIN_EN replaces fixed CPU priority (with
// the DBG_MAX_WAIT starvation guard) by alternating contested grants.
module dmem_arbiter #(
    parameter int DM_ADDRESS   = 9,
    parameter int DATA_W       = 32,
    parameter int DBG_MAX_WAIT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [DM_ADDRESS-1:0] cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    input  logic [2:0]            cpu_funct3,
    output logic                  cpu_gnt,
    output logic                  cpu_stall,
    output logic                  cpu_rvalid,
    output logic [DATA_W-1:0]     cpu_rdata,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [DM_ADDRESS-1:0] dbg_addr,
    input  logic [DATA_W-1:0]     dbg_wdata,
    input  logic [2:0]            dbg_funct3,
    output logic                  dbg_gnt,
    output logic                  dbg_rvalid,
    output logic [DATA_W-1:0]     dbg_rdata,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [DM_ADDRESS-1:0] a,
    output logic [DATA_W-1:0]     wd,
    output logic [2:0]            Funct3,
    input  logic [DATA_W-1:0]     rd
);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t state_q, state_d;

    logic                  dbg_win;
    logic                  we_q;
    logic                  owner_q;   // 0: CPU, 1: debug
    logic [DM_ADDRESS-1:0] addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [2:0]            f3_q;
    logic                  cpu_rvalid_q, dbg_rvalid_q;
    logic [DATA_W-1:0]     cpu_rdata_q, dbg_rdata_q;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic last_dbg_q;  // 1: debug won the most recent contested grant

    // Debug wins when alone, or when the CPU took the previous contest.
    always_comb begin
        dbg_win = dbg_req & (~cpu_req | ~last_dbg_q);
    end

    // Remember the winner of each contested cycle; reset favours the CPU next.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_dbg_q <= 1'b1;
        end else if (cpu_req & dbg_req) begin
            last_dbg_q <= dbg_win;
        end
    end
`else
    localparam logic [7:0] MAX_WAIT = 8'(DBG_MAX_WAIT);

    logic [7:0] dbg_wait_q, dbg_wait_d;

    // Debug wins when alone, or once it has lost DBG_MAX_WAIT cycles in a row.
    always_comb begin
        dbg_win = dbg_req & (~cpu_req | (dbg_wait_q == MAX_WAIT));
    end

    // Count consecutive lost cycles of a pending debug request, saturating.
    always_comb begin
        dbg_wait_d = dbg_wait_q;
        if (~dbg_req | dbg_gnt) begin
            dbg_wait_d = '0;
        end else if (dbg_wait_q != MAX_WAIT) begin
            dbg_wait_d = dbg_wait_q + 8'd1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            dbg_wait_q <= '0;
        end else begin
            dbg_wait_q <= dbg_wait_d;
        end
    end
`endif

    // Grants and stall; nothing is accepted while reset is high.
    always_comb begin
        cpu_gnt   = ~reset & cpu_req & ~dbg_win;
        dbg_gnt   = ~reset & dbg_win;
        cpu_stall = cpu_req & ~cpu_gnt;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: any accept leads to an ACCESS cycle.
    always_comb begin
        state_d = IDLE;
        if (cpu_gnt | dbg_gnt) begin
            state_d = ACCESS;
        end
    end

    // FSM outputs: memory strobes only during ACCESS, fields from the latch.
    always_comb begin
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        if (state_q == ACCESS) begin
            MemRead  = ~we_q;
            MemWrite = we_q;
        end
        a      = addr_q;
        wd     = wdata_q;
        Funct3 = f3_q;
    end

    // Latch the winning request's fields on the accept edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            owner_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
        end else if (cpu_gnt) begin
            we_q    <= cpu_we;
            owner_q <= 1'b0;
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            f3_q    <= cpu_funct3;
        end else if (dbg_gnt) begin
            we_q    <= dbg_we;
            owner_q <= 1'b1;
            addr_q  <= dbg_addr;
            wdata_q <= dbg_wdata;
            f3_q    <= dbg_funct3;
        end
    end

    // Register load data at the end of ACCESS and pulse the owner's valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            if ((state_q == ACCESS) && !we_q) begin
                if (owner_q) begin
                    dbg_rvalid_q <= 1'b1;
                    dbg_rdata_q  <= rd;
                end else begin
                    cpu_rvalid_q <= 1'b1;
                    cpu_rdata_q  <= rd;
                end
            end
        end
    end

    assign cpu_rvalid = cpu_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign dbg_rvalid = dbg_rvalid_q;
    assign dbg_rdata  = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int AW   = 9;
    localparam int DW   = 32;
    localparam int MAXW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, dbg_req, dbg_we;
    logic [AW-1:0] cpu_addr, dbg_addr;
    logic [DW-1:0] cpu_wdata, dbg_wdata;
    logic [2:0]    cpu_funct3, dbg_funct3;
    logic          cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid;
    logic [DW-1:0] cpu_rdata, dbg_rdata;
    logic          MemRead, MemWrite;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, rd;
    logic [2:0]    Funct3;

    always #5 clk = ~clk;

    dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW), .DBG_MAX_WAIT(MAXW)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_funct3(cpu_funct3),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_funct3(dbg_funct3),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .MemRead(MemRead), .MemWrite(MemWrite), .a(a), .wd(wd),
        .Funct3(Funct3), .rd(rd)
    );

    // Data memory seen by the DUT: word-organised, written during MemWrite.
    logic [DW-1:0] env_mem [128];
    assign rd = env_mem[a[8:2]];
    always @(posedge clk) if (MemWrite) env_mem[a[8:2]] <= wd;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: ordered transactions against its own copy of memory.
    logic [DW-1:0] ref_mem [128];
    logic          acc_v, acc_we, acc_own;
    logic [DW-1:0] acc_data;
    logic [AW-1:0] m_a;
    logic [DW-1:0] m_wd;
    logic [2:0]    m_f3;
    logic [1:0]    m_rv;
    logic [DW-1:0] m_rdata [2];
    int            m_losses;
    logic          m_last_dbg;

    // Observed DUT values from the latest step, for directed checks.
    logic g_cpu, g_dbg;
    logic o_cg, o_dg, o_stall, o_mr, o_mw, o_crv, o_drv;
    logic [AW-1:0] o_a;
    logic [DW-1:0] o_crd, o_drd;

    task automatic model_reset();
        acc_v = 0; acc_we = 0; acc_own = 0; acc_data = '0;
        m_a = '0; m_wd = '0; m_f3 = '0; m_rv = '0;
        m_rdata[0] = '0; m_rdata[1] = '0;
        m_losses = 0; m_last_dbg = 1'b1;
    endtask

    // One clock: inputs already set at negedge; check at +1, advance model at posedge.
    task automatic step();
        logic dw, e_cg, e_dg;
        #1;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        dw = dbg_req && (!cpu_req || !m_last_dbg);
`else
        dw = dbg_req && (!cpu_req || m_losses == MAXW);
`endif
        e_cg = !reset && cpu_req && !dw;
        e_dg = !reset && dw;
        o_cg = cpu_gnt; o_dg = dbg_gnt; o_stall = cpu_stall;
        o_mr = MemRead; o_mw = MemWrite; o_a = a;
        o_crv = cpu_rvalid; o_drv = dbg_rvalid; o_crd = cpu_rdata; o_drd = dbg_rdata;
        check("cpu_gnt", 64'(cpu_gnt), 64'(e_cg));
        check("dbg_gnt", 64'(dbg_gnt), 64'(e_dg));
        check("cpu_stall", 64'(cpu_stall), 64'(cpu_req && !e_cg));
        check("MemRead", 64'(MemRead), 64'(acc_v && !acc_we));
        check("MemWrite", 64'(MemWrite), 64'(acc_v && acc_we));
        check("a", 64'(a), 64'(m_a));
        check("wd", 64'(wd), 64'(m_wd));
        check("Funct3", 64'(Funct3), 64'(m_f3));
        check("cpu_rvalid", 64'(cpu_rvalid), 64'(m_rv[0]));
        check("dbg_rvalid", 64'(dbg_rvalid), 64'(m_rv[1]));
        check("cpu_rdata", 64'(cpu_rdata), 64'(m_rdata[0]));
        check("dbg_rdata", 64'(dbg_rdata), 64'(m_rdata[1]));
        g_cpu = e_cg; g_dbg = e_dg;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            m_rv = '0;
            if (acc_v && !acc_we) begin
                m_rv[acc_own]      = 1'b1;
                m_rdata[acc_own]   = acc_data;
            end
            if (dbg_req && !e_dg) m_losses = (m_losses < MAXW) ? m_losses + 1 : MAXW;
            else                  m_losses = 0;
            if (cpu_req && dbg_req) m_last_dbg = e_dg;
            acc_v = e_cg || e_dg;
            if (acc_v) begin
                acc_own = e_dg;
                acc_we  = e_dg ? dbg_we     : cpu_we;
                m_a     = e_dg ? dbg_addr   : cpu_addr;
                m_wd    = e_dg ? dbg_wdata  : cpu_wdata;
                m_f3    = e_dg ? dbg_funct3 : cpu_funct3;
                if (acc_we) ref_mem[m_a[8:2]] = m_wd;
                else        acc_data = ref_mem[m_a[8:2]];
            end
        end
        @(negedge clk);
    endtask

    task automatic rand_cpu();
        cpu_we     = 1'($urandom_range(0, 1));
        cpu_addr   = {7'($urandom_range(0, 127)), 2'b00};
        cpu_wdata  = $urandom;
        cpu_funct3 = 3'($urandom_range(0, 7));
    endtask

    task automatic rand_dbg();
        dbg_we     = 1'($urandom_range(0, 1));
        dbg_addr   = {7'($urandom_range(0, 127)), 2'b00};
        dbg_wdata  = $urandom;
        dbg_funct3 = 3'($urandom_range(0, 7));
    endtask

    task automatic cpu_set(input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wdat);
        cpu_req = 1; cpu_we = we; cpu_addr = ad; cpu_wdata = wdat; cpu_funct3 = 3'b010;
    endtask

    task automatic do_reset();
        reset = 1; step(); reset = 0;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            env_mem[i] = $urandom;
            ref_mem[i] = env_mem[i];
        end
        env_mem[4] = 32'hDEADBEEF;
        ref_mem[4] = 32'hDEADBEEF;
        reset = 1; cpu_req = 0; dbg_req = 0;
        rand_cpu(); rand_dbg();
        @(posedge clk);
        @(negedge clk);
        model_reset();
        do_reset();

        // Single CPU load from 0x010.
        cpu_set(0, 9'h010, '0);
        step();
        check("t1_gnt", 64'(o_cg), 64'd1);
        cpu_req = 0;
        step();
        check("t1_memread", 64'(o_mr), 64'd1);
        check("t1_addr", 64'(o_a), 64'h010);
        step();
        check("t1_rvalid", 64'(o_crv), 64'd1);
        check("t1_rdata", 64'(o_crd), 64'hDEADBEEF);
        check("t1_stall", 64'(o_stall), 64'd0);

        // Back-to-back store then load at 0x020.
        cpu_set(1, 9'h020, 32'h12345678);
        step();
        check("t2_gnt0", 64'(o_cg), 64'd1);
        cpu_set(0, 9'h020, '0);
        step();
        check("t2_gnt1", 64'(o_cg), 64'd1);
        check("t2_memwrite", 64'(o_mw), 64'd1);
        cpu_req = 0;
        step();
        check("t2_memread", 64'(o_mr), 64'd1);
        step();
        check("t2_rdata", 64'(o_crd), 64'h12345678);

        // Contention right after reset: CPU first, then debug.
        do_reset();
        cpu_set(0, 9'h040, '0);
        dbg_req = 1; dbg_we = 0; dbg_addr = 9'h044; dbg_funct3 = 3'b010;
        step();
        check("ct_cpu0", 64'(o_cg), 64'd1);
        check("ct_dbg0", 64'(o_dg), 64'd0);
        cpu_req = 0;
        step();
        check("ct_dbg1", 64'(o_dg), 64'd1);
        check("ct_cpu1", 64'(o_cg), 64'd0);
        dbg_req = 0;
        step();
        step();

`ifdef DMEM_ARB_ROUND_ROBIN_EN
        // Both held: grants alternate CPU, DBG, ... from the first contest after reset.
        do_reset();
        cpu_req = 1; rand_cpu(); dbg_req = 1; rand_dbg();
        for (int c = 0; c < 8; c++) begin
            step();
            check("rr_dbg", 64'(o_dg), 64'(c % 2));
            if (g_cpu) rand_cpu();
            if (g_dbg) rand_dbg();
        end
`else
        // Both held: debug forced through every ninth cycle.
        cpu_req = 1; rand_cpu(); dbg_req = 1; rand_dbg();
        for (int c = 0; c < 18; c++) begin
            step();
            check("starve_dbg", 64'(o_dg), 64'((c == 8) || (c == 17)));
            if (c == 8) check("starve_stall", 64'(o_stall), 64'd1);
            if (g_cpu) rand_cpu();
            if (g_dbg) rand_dbg();
        end
`endif
        cpu_req = 0; dbg_req = 0;
        step();
        step();

        // Reset in the ACCESS cycle of a CPU load drops it.
        cpu_set(0, 9'h010, '0);
        step();
        cpu_req = 0; reset = 1;
        step();
        reset = 0;
        step();
        check("rst_memread", 64'(o_mr), 64'd0);
        check("rst_rvalid", 64'(o_crv), 64'd0);
        check("rst_addr", 64'(o_a), 64'd0);
        check("rst_rdata", 64'(o_crd), 64'd0);
        step();
        check("rst_rvalid2", 64'(o_crv), 64'd0);
        cpu_set(0, 9'h010, '0);
        step();
        cpu_req = 0;
        step();
        step();
        check("rst_after_rvalid", 64'(o_crv), 64'd1);
        check("rst_after_rdata", 64'(o_crd), 64'hDEADBEEF);

        // Randomized traffic with occasional resets.
        for (int t = 0; t < 3000; t++) begin
            reset = ($urandom_range(0, 59) == 0);
            if (!cpu_req || g_cpu) begin
                cpu_req = ($urandom_range(0, 3) != 0);
                rand_cpu();
            end
            if (!dbg_req || g_dbg) begin
                dbg_req = ($urandom_range(0, 1) != 0);
                rand_dbg();
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
